md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  EX-stage multiply/divide unit with HI/LO registers. Sits beside the ALU, feeding the EX/MEM pipeline register.
//  Accepts mult/multu/div/divu/mthi/mtlo from the ID/EX register.
//  Models multi-cycle latency with a busy flag; the hazard unit stalls ID on busy.
//  mfhi/mflo read HI/LO through this block and pass to EX/MEM as the ALU result.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (1..31)
//  DIV_CYCLES   10  busy cycles for div/divu (1..31)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low; clears all state
//  start      in   1   1-cycle request; valid only with md_op 0..3
//  md_op      in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
//  A          in   32  rs operand (forwarded)
//  B          in   32  rt operand (forwarded)
//  busy       out  1   operation in progress
//  stall_req  out  1   start | busy; ID stalls any md instruction on this
//  md_out     out  32  HI when md_op==6, LO when md_op==7, else 0 (combinational)
//  HI         out  32  current HI register
//  LO         out  32  current LO register
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, counter=0, busy=0, HI=0, LO=0, temp regs=0.
//  - FSM states:
//    - IDLE -> MULT on start & md_op in {0,1}.
//    - IDLE -> DIV on start & md_op in {2,3}.
//    - MULT/DIV -> IDLE when counter reaches MULT_CYCLES/DIV_CYCLES.
//  - Start edge: operands sampled, full result computed into temp_hi/temp_lo, counter=1, busy=1.
//    - busy=1 for exactly N cycles after the start edge.
//    - HI/LO take temp values on the edge where busy falls; visible the same cycle busy reads 0.
//  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
//  - multu: {HI,LO} = unsigned 64-bit product.
//  - div: LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
//    - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  - divu: unsigned LO=A/B, HI=A%B.
//  - Divide by zero (B==0): still busy for DIV_CYCLES; HI/LO left unchanged at completion.
//  - mthi/mtlo (md_op 4/5 with start=0): write HI/LO = A at next edge, only when busy==0 and state IDLE.
//    - Ignored while busy; the hazard unit guarantees this never occurs.
//  - start while busy: ignored, no effect on current op or counter.
//  - start with md_op 4..7: ignored.
//  - stall_req = start | busy, combinational, no register delay.
//  - md_out: purely combinational from HI/LO; reflects mthi/mtlo from the following cycle.
//  - Reset mid-operation: pending result discarded; HI/LO = 0.
// TESTING
//  - Reset sequence:
//    - Pulse reset low mid-mult -> busy=0, HI=LO=0 immediately (async).
//    - No HI/LO update after reset release.
//  - mult: start, md_op=0, A=0xFFFFFFFE (-2), B=3.
//    - busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  - multu: same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
//  - div: A=-7 (0xFFFFFFF9), B=2.
//    - After 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  - Corner cases:
//    - divu A=7, B=0 -> HI/LO unchanged after 10 cycles.
//    - div 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  - Control interactions:
//    - Second start issued on busy cycle 2 -> ignored; busy drops on original schedule.
//    - mthi A=0x1234 -> HI=0x1234 next cycle; md_op=6 -> md_out=0x1234.

Source files
------------

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit with HI/LO registers.
// Multi-cycle latency is modelled by a busy counter.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] md_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [4:0]  counter, counter_n;
    logic        done;
    logic        op_start;
    logic [31:0] temp_hi, temp_lo;
    logic        temp_dz;

    logic        is_signed;
    logic [63:0] mul_s, mul_u;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag, q_res, r_res;
    logic [31:0] res_hi, res_lo;

    assign busy      = (state != IDLE);
    assign stall_req = start | busy;
    assign op_start  = start && (state == IDLE) && !md_op[2];
    assign is_signed = ~md_op[0];

    // Full result computed up front from the operands present on the start edge;
    // signed divide works on magnitudes so MIN/-1 wraps cleanly to MIN.
    always_comb begin
        mul_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        mul_u  = {32'b0, A} * {32'b0, B};
        a_mag  = (is_signed && A[31]) ? -A : A;
        b_mag  = (is_signed && B[31]) ? -B : B;
        b_safe = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q_res  = (is_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
        r_res  = (is_signed && A[31]) ? -r_mag : r_mag;
        if (md_op[1]) begin
            res_hi = r_res;
            res_lo = q_res;
        end else if (is_signed) begin
            res_hi = mul_s[63:32];
            res_lo = mul_s[31:0];
        end else begin
            res_hi = mul_u[63:32];
            res_lo = mul_u[31:0];
        end
    end

    // Next-state and cycle counter; done pulses on the edge where busy falls.
    always_comb begin
        state_n   = state;
        counter_n = counter;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (op_start) begin
                    state_n   = md_op[1] ? DIV : MULT;
                    counter_n = 5'd1;
                end
            end
            MULT: begin
                if (counter == MULT_N) begin
                    state_n   = IDLE;
                    counter_n = 5'd0;
                    done      = 1'b1;
                end else begin
                    counter_n = counter + 5'd1;
                end
            end
            DIV: begin
                if (counter == DIV_N) begin
                    state_n   = IDLE;
                    counter_n = 5'd0;
                    done      = 1'b1;
                end else begin
                    counter_n = counter + 5'd1;
                end
            end
            default: begin
                state_n   = IDLE;
                counter_n = 5'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= 5'd0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
        end
    end

    // Latch the pending result and divide-by-zero flag on the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            temp_dz <= 1'b0;
        end else if (op_start) begin
            temp_hi <= res_hi;
            temp_lo <= res_lo;
            temp_dz <= md_op[1] && (B == 32'd0);
        end
    end

    // HI/LO commit on completion, or direct writes from mthi/mtlo when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (done) begin
            if (!temp_dz) begin
                HI <= temp_hi;
                LO <= temp_lo;
            end
        end else if (state == IDLE && !start) begin
            if (md_op == 3'd4) HI <= A;
            if (md_op == 3'd5) LO <= A;
        end
    end

    // mfhi/mflo read path.
    always_comb begin
        md_out = 32'd0;
        if (md_op == 3'd6) md_out = HI;
        if (md_op == 3'd7) md_out = LO;
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;
    int cyc;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .md_out    (md_out),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        #1 check("stall_req_start", {31'b0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_stall", {31'b0, stall_req}, 32'd0);

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, cyc);
        check("mult_cyc", cyc, 32'd5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFA);

        run_op(3'd1, 32'hFFFFFFFE, 32'd3, cyc);
        check("multu_cyc", cyc, 32'd5);
        check("multu_hi", HI, 32'h00000002);
        check("multu_lo", LO, 32'hFFFFFFFA);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc);
        check("div_cyc", cyc, 32'd10);
        check("div_hi", HI, 32'hFFFFFFFF);
        check("div_lo", LO, 32'hFFFFFFFD);

        run_op(3'd3, 32'd7, 32'd0, cyc);
        check("dz_cyc", cyc, 32'd10);
        check("dz_hi", HI, 32'hFFFFFFFF);
        check("dz_lo", LO, 32'hFFFFFFFD);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("ovf_hi", HI, 32'd0);
        check("ovf_lo", LO, 32'h80000000);

        run_op(3'd2, 32'd7, 32'hFFFFFFFE, cyc);
        check("divneg_hi", HI, 32'd1);
        check("divneg_lo", LO, 32'hFFFFFFFD);

        run_op(3'd3, 32'd100, 32'd7, cyc);
        check("divu_hi", HI, 32'd2);
        check("divu_lo", LO, 32'd14);

        // second start on busy cycle 2 must be ignored
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd0;
        A     = 32'd2;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 64) begin
            cyc++;
            start = (cyc == 2);
            md_op = 3'd2;
            A     = 32'd100;
            B     = 32'd7;
            @(negedge clk);
        end
        start = 1'b0;
        md_op = 3'd0;
        check("restart_cyc", cyc, 32'd5);
        check("restart_hi", HI, 32'd0);
        check("restart_lo", LO, 32'd6);
        @(negedge clk);
        check("restart_idle", {31'b0, busy}, 32'd0);

        // start with a non-arith op is ignored
        start = 1'b1;
        md_op = 3'd6;
        #1 check("bad_op_stall", {31'b0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("bad_op_busy", {31'b0, busy}, 32'd0);

        // mthi / mtlo then mfhi / mflo
        md_op = 3'd4;
        A     = 32'h1234;
        @(negedge clk);
        md_op = 3'd6;
        A     = 32'd0;
        #1;
        check("mthi_hi", HI, 32'h1234);
        check("mfhi_out", md_out, 32'h1234);
        @(negedge clk);
        md_op = 3'd5;
        A     = 32'h5678;
        @(negedge clk);
        md_op = 3'd7;
        A     = 32'd0;
        #1;
        check("mtlo_lo", LO, 32'h5678);
        check("mflo_out", md_out, 32'h5678);
        check("mtlo_hi_kept", HI, 32'h1234);
        md_op = 3'd0;
        #1 check("md_out_zero", md_out, 32'd0);

        // reset pulse in the middle of a mult
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd0;
        A     = 32'd5;
        B     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_busy", {31'b0, busy}, 32'd0);
        check("async_hi", HI, 32'd0);
        check("async_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
